// File: rtl/pep_mmacc_acc_join_pkg.sv
// Shared parameters and payload types for the main/subs accumulator join.
// Holds the common lane geometry plus the local-slice types built from it.
package pep_mmacc_acc_join_pkg;

    localparam int unsigned PSI       = 4;
    localparam int unsigned R         = 2;
    localparam int unsigned MAIN_PSI  = 2;
    localparam int unsigned LOC_PSI   = PSI - MAIN_PSI;
    localparam int unsigned MOD_Q_W   = 8;
    localparam int unsigned BPBS_ID_W = 4;

    typedef struct packed {
        logic [MAIN_PSI-1:0][R-1:0][MOD_Q_W-1:0] data;
        logic                                    sob;
        logic                                    eob;
        logic                                    sol;
        logic                                    eol;
        logic                                    sog;
        logic                                    eog;
        logic [BPBS_ID_W-1:0]                    pbs_id;
    } subsmain_acc_data_t;

    typedef struct packed {
        logic [LOC_PSI-1:0][R-1:0][MOD_Q_W-1:0] data;
        logic                                   sob;
        logic                                   eob;
        logic                                   sol;
        logic                                   eol;
        logic                                   sog;
        logic                                   eog;
        logic [BPBS_ID_W-1:0]                   pbs_id;
    } loc_acc_data_t;

    typedef struct packed {
        logic [PSI-1:0][R-1:0][MOD_Q_W-1:0] data;
        logic                               sob;
        logic                               eob;
        logic                               sol;
        logic                               eol;
        logic                               sog;
        logic                               eog;
        logic [BPBS_ID_W-1:0]               pbs_id;
    } ntt_acc_modsw_data_t;

    typedef struct packed {
        logic [PSI-1:0][R-1:0] data_avail;
        logic                  ctrl_avail;
    } ntt_acc_modsw_ctrl_t;

    localparam int unsigned SUBSMAIN_ACC_DATA_W = $bits(subsmain_acc_data_t);
    localparam int unsigned LOC_ACC_DATA_W      = $bits(loc_acc_data_t);

    // True when the two halves disagree on any framing/control field.
    function automatic logic acc_ctrl_mismatch(input subsmain_acc_data_t s,
                                               input loc_acc_data_t      l);
        return {s.sob, s.eob, s.sol, s.eol, s.sog, s.eog, s.pbs_id} !=
               {l.sob, l.eob, l.sol, l.eol, l.sog, l.eog, l.pbs_id};
    endfunction

endpackage

// File: rtl/pep_mmacc_acc_join_fifo.sv
// Register-based skew FIFO with fall-through head; refuses a push when full
// unless a pop frees the slot in the same cycle.
module pep_mmacc_acc_join_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head_c,
    output logic             empty_c,
    output logic             full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty_c = (count == '0);
    assign full_c  = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty_c;
    assign do_push = push & (~full_c | do_pop);
    assign head_c  = mem[rd_ptr];

    // Pointers wrap on their own since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/pep_mmacc_acc_join.sv
// Re-joins the subs-returned accumulator slice with the local slice into one
// full-width mod-switch beat, absorbing link skew and flagging mismatch/overflow.
module pep_mmacc_acc_join
    import pep_mmacc_acc_join_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                s_rst_n,
    input  subsmain_acc_data_t  subs_acc_data,
    input  logic                subs_acc_avail,
    input  loc_acc_data_t       loc_acc_data,
    input  logic                loc_acc_avail,
    output ntt_acc_modsw_data_t out_data,
    output ntt_acc_modsw_ctrl_t out_ctrl,
    output logic [1:0]          error
);

    logic [SUBSMAIN_ACC_DATA_W-1:0] subs_head_c;
    logic [LOC_ACC_DATA_W-1:0]      loc_head_c;
    logic                           subs_empty_c;
    logic                           subs_full_c;
    logic                           loc_empty_c;
    logic                           loc_full_c;
    logic                           pop_c;
    logic                           mismatch_c;
    logic                           overflow_c;
    subsmain_acc_data_t             subs_head;
    loc_acc_data_t                  loc_head;
    ntt_acc_modsw_data_t            join_c;

    pep_mmacc_acc_join_fifo #(
        .WIDTH (SUBSMAIN_ACC_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_subs_fifo (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .push    (subs_acc_avail),
        .pop     (pop_c),
        .wdata   (subs_acc_data),
        .head_c  (subs_head_c),
        .empty_c (subs_empty_c),
        .full_c  (subs_full_c)
    );

    pep_mmacc_acc_join_fifo #(
        .WIDTH (LOC_ACC_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_loc_fifo (
        .clk     (clk),
        .s_rst_n (s_rst_n),
        .push    (loc_acc_avail),
        .pop     (pop_c),
        .wdata   (loc_acc_data),
        .head_c  (loc_head_c),
        .empty_c (loc_empty_c),
        .full_c  (loc_full_c)
    );

    assign subs_head  = subsmain_acc_data_t'(subs_head_c);
    assign loc_head   = loc_acc_data_t'(loc_head_c);
    assign pop_c      = ~subs_empty_c & ~loc_empty_c;
    assign mismatch_c = acc_ctrl_mismatch(subs_head, loc_head);
    // A full side only loses its beat when no pop frees a slot this cycle.
    assign overflow_c = ~pop_c & ((subs_acc_avail & subs_full_c) |
                                  (loc_acc_avail  & loc_full_c));

    // Subs lanes fill the low slots; control fields follow the local slice.
    always_comb begin
        join_c                      = '0;
        join_c.data[MAIN_PSI-1:0]   = subs_head.data;
        join_c.data[PSI-1:MAIN_PSI] = loc_head.data;
        join_c.sob                  = loc_head.sob;
        join_c.eob                  = loc_head.eob;
        join_c.sol                  = loc_head.sol;
        join_c.eol                  = loc_head.eol;
        join_c.sog                  = loc_head.sog;
        join_c.eog                  = loc_head.eog;
        join_c.pbs_id               = loc_head.pbs_id;
    end

    always_ff @(posedge clk) begin
        if (!s_rst_n) begin
            out_ctrl <= '0;
            error    <= '0;
        end else begin
            out_ctrl.data_avail <= pop_c ? '1 : '0;
            out_ctrl.ctrl_avail <= pop_c;
            error               <= {overflow_c, pop_c & mismatch_c};
        end
    end

    always_ff @(posedge clk) begin
        if (pop_c) out_data <= join_c;
    end

endmodule
